cpu4_ctrl_fsm: RTL

Multicycle main controller for the 32-bit cpu4 datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It does this by driving the datapath's PC, IR, register-file, ALU-mux, ALU-op and memory enables from the instruction's Op/Funct fields and the ALU zero flag. It replaces ad-hoc control decode and is instantiated inside cpu4 between the IR and the datapath muxes.

---
 rtl/cpu4_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu4_ctrl_fsm.sv
// Multicycle main controller for the cpu4 datapath: fetch/decode/execute/memory/writeback sequencing.
// Outputs are registered alongside the state (Moore). The only exception is PCEn in BRANCH, which follows zero combinationally.
// No backpressure: a new instruction is fetched every 3-5 cycles, depending on its class.
module cpu4_ctrl_fsm #(
    parameter int ALUC_W = 11,
    parameter int ST_W   = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [5:0]        Op,
    input  logic [5:0]        Funct,
    input  logic              zero,
    output logic              PCEn,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [1:0]        PCSrc,
    output logic              RD,
    output logic              WD,
    output logic              signext,
    output logic              MemOrReg,
    output logic              illegal,
    output logic [ST_W-1:0]   state
);

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC_R  = 4'd7,
        S_ALUWB_R = 4'd8,
        S_EXEC_I  = 4'd9,
        S_ALUWB_I = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_TRAP    = 4'd13
    } st_e;

    typedef struct packed {
        logic              pcen;
        logic              irwrite;
        logic              regdst;
        logic              regwrite;
        logic              alusrca;
        logic [1:0]        alusrcb;
        logic [ALUC_W-1:0] aluc;
        logic [1:0]        pcsrc;
        logic              rd;
        logic              wd;
        logic              signext;
        logic              memorreg;
        logic              illegal;
    } ctl_t;

    // One-hot ALU select positions
    localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR  = 3, A_XOR = 4, A_NOR = 5;
    localparam int A_SLT = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9, A_LUI = 10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    st_e        st_q;
    st_e        nxt;
    ctl_t       ctl_q;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [5:0] op_sel;
    logic [5:0] fn_sel;

    // R-type funct to one-hot ALU op; all-zero means the funct is not decodable
    function automatic logic [ALUC_W-1:0] r_alu(input logic [5:0] fn);
        logic [ALUC_W-1:0] a;
        a = '0;
        case (fn)
            6'b100000: a[A_ADD] = 1'b1;
            6'b100010: a[A_SUB] = 1'b1;
            6'b100100: a[A_AND] = 1'b1;
            6'b100101: a[A_OR]  = 1'b1;
            6'b100110: a[A_XOR] = 1'b1;
            6'b100111: a[A_NOR] = 1'b1;
            6'b101010: a[A_SLT] = 1'b1;
            6'b000000: a[A_SLL] = 1'b1;
            6'b000010: a[A_SRL] = 1'b1;
            6'b000011: a[A_SRA] = 1'b1;
            default:   a = '0;
        endcase
        return a;
    endfunction

    // I-type ALU opcode to one-hot ALU op; all-zero for anything else
    function automatic logic [ALUC_W-1:0] i_alu(input logic [5:0] op);
        logic [ALUC_W-1:0] a;
        a = '0;
        case (op)
            OP_ADDI: a[A_ADD] = 1'b1;
            OP_ANDI: a[A_AND] = 1'b1;
            OP_ORI:  a[A_OR]  = 1'b1;
            OP_XORI: a[A_XOR] = 1'b1;
            OP_SLTI: a[A_SLT] = 1'b1;
            OP_LUI:  a[A_LUI] = 1'b1;
            default: a = '0;
        endcase
        return a;
    endfunction

    // Control word for a state; op/fn are the instruction fields valid when that state is entered
    function automatic ctl_t ctl_for(input st_e s, input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite     = 1'b1;
                c.pcen        = 1'b1;
                c.alusrcb     = 2'b01;
                c.aluc[A_ADD] = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb     = 2'b11;
                c.aluc[A_ADD] = 1'b1;
                c.signext     = 1'b1;
            end
            S_MEMADR: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = 2'b10;
                c.aluc[A_ADD] = 1'b1;
                c.signext     = 1'b1;
            end
            S_MEMRD: c.rd = 1'b1;
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memorreg = 1'b1;
            end
            S_MEMWR: c.wd = 1'b1;
            S_EXEC_R: begin
                c.alusrca = 1'b1;
                c.aluc    = r_alu(fn);
            end
            S_ALUWB_R: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_EXEC_I: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluc    = i_alu(op);
                c.signext = (op == OP_ADDI) || (op == OP_SLTI);
            end
            S_ALUWB_I: c.regwrite = 1'b1;
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluc[A_SUB] = 1'b1;
                c.pcsrc       = 2'b01;
            end
            S_JUMP: begin
                c.pcsrc = 2'b10;
                c.pcen  = 1'b1;
            end
            S_TRAP:  c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // While decoding, the fields come straight from the IR; afterwards, from the latched copy
    assign op_sel = (st_q == S_DECODE) ? Op    : op_q;
    assign fn_sel = (st_q == S_DECODE) ? Funct : funct_q;

    // Next-state selection
    always_comb begin
        nxt = S_FETCH;
        case (st_q)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_RTYPE: nxt = (r_alu(Funct) != '0) ? S_EXEC_R : S_TRAP;
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: nxt = S_EXEC_I;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_J:     nxt = S_JUMP;
                    default:  nxt = S_TRAP;
                endcase
            end
            S_MEMADR: nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = S_MEMWB;
            S_EXEC_R: nxt = S_ALUWB_R;
            S_EXEC_I: nxt = S_ALUWB_I;
            default:  nxt = S_FETCH;
        endcase
    end

    // State, latched instruction fields and registered control word
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            st_q    <= S_IDLE;
            ctl_q   <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            st_q  <= nxt;
            ctl_q <= ctl_for(nxt, op_sel, fn_sel);
            if (st_q == S_DECODE) begin
                op_q    <= Op;
                funct_q <= Funct;
            end
        end
    end

    // Branch decision is the only output that follows zero within the cycle
    assign PCEn       = ctl_q.pcen |
                        ((st_q == S_BRANCH) && ((op_q == OP_BNE) ? ~zero : zero));
    assign IRWrite    = ctl_q.irwrite;
    assign RegDst     = ctl_q.regdst;
    assign RegWrite   = ctl_q.regwrite;
    assign ALUSrcA    = ctl_q.alusrca;
    assign ALUSrcB    = ctl_q.alusrcb;
    assign ALUControl = ctl_q.aluc;
    assign PCSrc      = ctl_q.pcsrc;
    assign RD         = ctl_q.rd;
    assign WD         = ctl_q.wd;
    assign signext    = ctl_q.signext;
    assign MemOrReg   = ctl_q.memorreg;
    assign illegal    = ctl_q.illegal;
    assign state      = st_q;

endmodule
